// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit cache-line request to a four-beat 64-bit memory burst.
// Define CACHELINE_ADAPTOR_ALIGN_EN to force address_o onto a 32-byte line boundary.
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e       state_q, state_d;
    logic [1:0]   k_q, k_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wdata_q, wdata_d;
    logic [255:0] rbuf_q, rbuf_d;
    logic [255:0] rdata_q, rdata_d;
    logic [7:0]   beat_lsb;

    assign beat_lsb = {k_q, 6'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (pmem_read) begin
                    addr_d  = pmem_address;
                    k_d     = '0;
                    state_d = StRead;
                end else if (pmem_write) begin
                    addr_d  = pmem_address;
                    wdata_d = pmem_wdata;
                    k_d     = '0;
                    state_d = StWrite;
                end
            end
            StRead: begin
                if (resp_i) begin
                    rbuf_d[beat_lsb +: 64] = burst_i;
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        // Publish the whole line at once so a partial fill is never visible.
                        rdata_d = {burst_i, rbuf_q[191:0]};
                        k_d     = '0;
                        state_d = StDone;
                    end
                end
            end
            StWrite: begin
                if (resp_i) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        k_d     = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign read_o     = (state_q == StRead);
    assign write_o    = (state_q == StWrite);
    assign pmem_resp  = (state_q == StDone);
    assign pmem_rdata = rdata_q;
    assign burst_o    = (state_q == StWrite) ? wdata_q[beat_lsb +: 64] : 64'd0;

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    assign address_o = {addr_q[31:5], 5'b0};
`else
    assign address_o = addr_q;
`endif

endmodule
